// File: rtl/ff_write_arbiter.sv
// Round-robin arbiter in front of one shared W-bit register (Q/nQ).
// A winning requester may lock the register for up to MAXLOCK consecutive cycles.
module ff_write_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int MAXLOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        owner,
    output logic              locked,
    output logic [W-1:0]      Q,
    output logic [W-1:0]      nQ
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXLOCK + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]      state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [CW-1:0]   lockcnt_reg, lockcnt_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [W-1:0]    q_reg, q_next;
    logic            locked_reg, locked_next;

    // Candidate k for search slot gi is (ptr + 1 + gi) mod NREQ.
    logic [IW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum          = {1'b0, ptr_reg} + (IW+1)'(gi + 1);
            assign cand_idx[gi] = IW'((sum >= (IW+1)'(NREQ)) ? (sum - (IW+1)'(NREQ)) : sum);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    logic          win_valid;
    logic [IW-1:0] win_idx;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    logic timeout;
    assign timeout = (lockcnt_reg == CW'(MAXLOCK));

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        owner_next   = owner_reg;
        lockcnt_next = lockcnt_reg;
        gnt_next     = '0;
        q_next       = q_reg;
        locked_next  = locked_reg;
        if (state_reg == S_IDLE) begin
            locked_next = 1'b0;
            if (win_valid) begin
                q_next     = wdata[win_idx*W +: W];
                gnt_next   = NREQ'(1) << win_idx;
                owner_next = win_idx;
                ptr_next   = win_idx;
                if (lock[win_idx]) begin
                    state_next   = S_LOCKED;
                    locked_next  = 1'b1;
                    lockcnt_next = CW'(1);
                end
            end
        end else begin
            lockcnt_next = lockcnt_reg + CW'(1);
            if (req[owner_reg]) begin
                q_next   = wdata[owner_reg*W +: W];
                gnt_next = NREQ'(1) << owner_reg;
            end
            // Release still lets this edge's write land; no relock in the same cycle.
            if (!lock[owner_reg] || timeout) begin
                state_next   = S_IDLE;
                locked_next  = 1'b0;
                lockcnt_next = '0;
                if (timeout) begin
                    ptr_next = owner_reg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            ptr_reg     <= IW'(NREQ - 1);
            owner_reg   <= '0;
            lockcnt_reg <= '0;
            gnt_reg     <= '0;
            q_reg       <= '0;
            locked_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            owner_reg   <= owner_next;
            lockcnt_reg <= lockcnt_next;
            gnt_reg     <= gnt_next;
            q_reg       <= q_next;
            locked_reg  <= locked_next;
        end
    end

    assign gnt    = gnt_reg;
    assign owner  = 3'(owner_reg);
    assign locked = locked_reg;
    assign Q      = q_reg;
    assign nQ     = ~q_reg;
endmodule

// File: tb/tb_ff_write_arbiter.sv
// Directed bench for ff_write_arbiter: each step queues its expected register
// outputs and checks them one edge later.
module tb_ff_write_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [NREQ*W-1:0] wdata = 32'h13121110;
    logic [NREQ-1:0]   gnt;
    logic [2:0]        owner;
    logic              locked;
    logic [W-1:0]      Q;
    logic [W-1:0]      nQ;

    ff_write_arbiter #(.NREQ(NREQ), .W(W), .MAXLOCK(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .gnt    (gnt),
        .owner  (owner),
        .locked (locked),
        .Q      (Q),
        .nQ     (nQ)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [2:0] owner;
        logic       locked;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stepno = 0;

    // Drive inputs, queue the expectation, then check after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [3:0] eg, input logic [7:0] eq,
                        input logic [2:0] eo, input logic el);
        exp_t e;
        rst  = r;
        req  = rq;
        lock = lk;
        exp_q.push_back('{gnt: eg, q: eq, owner: eo, locked: el});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        stepno++;
        tests += 5;
        assert (gnt === e.gnt) else begin
            fails++;
            $error("FAIL step%0d gnt: got %b expected %b", stepno, gnt, e.gnt);
        end
        assert (Q === e.q) else begin
            fails++;
            $error("FAIL step%0d Q: got %h expected %h", stepno, Q, e.q);
        end
        assert (nQ === ~e.q) else begin
            fails++;
            $error("FAIL step%0d nQ: got %h expected %h", stepno, nQ, ~e.q);
        end
        assert (owner === e.owner) else begin
            fails++;
            $error("FAIL step%0d owner: got %0d expected %0d", stepno, owner, e.owner);
        end
        assert (locked === e.locked) else begin
            fails++;
            $error("FAIL step%0d locked: got %b expected %b", stepno, locked, e.locked);
        end
        $display("[TB] step %0d rst=%b req=%b lock=%b -> gnt=%b Q=%h owner=%0d locked=%b",
                 stepno, r, rq, lk, gnt, Q, owner, locked);
    endtask

    initial begin
        // Reset, then idle
        step(1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0);
        // Full round robin starting at requester 0
        step(0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 0, 0);
        step(0, 4'b1111, 4'b0000, 4'b0010, 8'h11, 1, 0);
        step(0, 4'b1111, 4'b0000, 4'b0100, 8'h12, 2, 0);
        step(0, 4'b1111, 4'b0000, 4'b1000, 8'h13, 3, 0);
        step(0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 0, 0);
        step(0, 4'b1111, 4'b0000, 4'b0010, 8'h11, 1, 0);
        step(0, 4'b1111, 4'b0000, 4'b0100, 8'h12, 2, 0);
        step(0, 4'b1111, 4'b0000, 4'b1000, 8'h13, 3, 0);
        // Single request after a grant to 3, then no request holds Q
        step(0, 4'b0100, 4'b0000, 4'b0100, 8'h12, 2, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 8'h12, 2, 0);
        // Lock timeout: ptr=2 so requester 3 wins first, then 1 locks
        step(0, 4'b1010, 4'b0010, 4'b1000, 8'h13, 3, 0);
        step(0, 4'b1010, 4'b0010, 4'b0010, 8'h11, 1, 1);
        for (int i = 0; i < 7; i++)
            step(0, 4'b1010, 4'b0010, 4'b0010, 8'h11, 1, 1);
        step(0, 4'b1010, 4'b0010, 4'b0010, 8'h11, 1, 0);
        step(0, 4'b1010, 4'b0010, 4'b1000, 8'h13, 3, 0);
        step(0, 4'b1010, 4'b0010, 4'b0010, 8'h11, 1, 1);
        // Owner idles while locked: others ignored, no grant
        step(0, 4'b1000, 4'b0010, 4'b0000, 8'h11, 1, 1);
        // Lock drop: write lands and locked falls on the same edge
        step(0, 4'b1010, 4'b0000, 4'b0010, 8'h11, 1, 0);
        step(0, 4'b1011, 4'b0000, 4'b1000, 8'h13, 3, 0);
        // Requester 0 locks, drops lock, next search starts at 1
        step(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 0, 1);
        step(0, 4'b0011, 4'b0000, 4'b0001, 8'h10, 0, 0);
        step(0, 4'b0011, 4'b0000, 4'b0010, 8'h11, 1, 0);
        // Reset in the middle of a lock
        step(0, 4'b0100, 4'b0100, 4'b0100, 8'h12, 2, 1);
        step(0, 4'b0101, 4'b0100, 4'b0100, 8'h12, 2, 1);
        step(1, 4'b1111, 4'b1111, 4'b0000, 8'h00, 0, 0);
        step(0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 0, 0);
        step(0, 4'b1111, 4'b0000, 4'b0010, 8'h11, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
